// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter slice:
//   - DATA_W / SEL_W : operand/result width and opcode width
//   - alu_op_e       : ALU opcode encoding (ALU_ADD .. ALU_SHR)
//   - arb_state_e    : arbiter FSM state encoding
//   - alu_op_t       : one latched ALU operation (operands + opcode)
//   - pick_grant     : arbitration decision helper
package alu_arbiter_pkg;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           sel;
  } alu_op_t;

  // Returns the requester id to grant. Under contention, round-robin mode
  // hands the slot to whoever did not finish last; fixed mode always
  // favours requester 0. A lone requester is always granted.
  function automatic logic pick_grant(input logic v0, input logic v1,
                                      input logic last_id, input logic rr_en);
    logic id;
    id = 1'b0;
    if (v0 && v1) begin
      id = rr_en ? ~last_id : 1'b0;
    end else if (v1) begin
      id = 1'b1;
    end
    return id;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
// Purely combinational 4-bit ALU shared by the arbiter.
// Ports:
//   a, b  in  DATA_W  operands
//   sel   in  alu_op_e opcode
//   y     out DATA_W  result
//   cout  out 1       carry-out for add, borrow (a < b) for sub, else 0
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           sel,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [1:0]        shamt;

  // The extra top bit of the widened difference is set exactly when the
  // unsigned subtraction wraps, so it doubles as the borrow flag. Shift
  // amounts only look at b[1:0]; b[3:2] are deliberately ignored.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    shamt = b[1:0];
    y     = '0;
    cout  = 1'b0;
    case (sel)
      ALU_ADD: begin
        y    = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      ALU_SUB: begin
        y    = diff[DATA_W-1:0];
        cout = diff[DATA_W];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = ~a;
      ALU_SHL: y = a << shamt;
      ALU_SHR: y = a >> shamt;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto a single shared ALU. One operation is in
// flight at a time: IDLE accepts, EXEC computes from latched operands into
// the result register, RESP presents the result until the owner consumes it.
// Parameters:
//   RR_EN       1 = round-robin under contention, 0 = requester 0 always wins
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (N = 0,1)
//   reqN_a/b/sel          operands and opcode for requester N
//   rspN_valid/ready      response handshake for requester N
//   rspN_y/cout           result and carry/borrow for requester N
//   busy                  high whenever the FSM is not IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_y,
  output logic              rsp0_cout,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_y,
  output logic              rsp1_cout,
  output logic              busy
);

  arb_state_e        state;
  arb_state_e        state_next;
  alu_op_t           op_q;
  alu_op_t           op_in;
  logic              grant_q;
  logic              last_q;
  logic              grant_pick;
  logic              accept;
  logic              resp_done;
  logic [DATA_W-1:0] y_q;
  logic              cout_q;
  logic [DATA_W-1:0] alu_y;
  logic              alu_cout;

  // Decide who would win the slot this cycle and mux that requester's
  // operation so it can be latched on the accepting edge.
  always_comb begin
    grant_pick = pick_grant(req0_valid, req1_valid, last_q, RR_EN);
    if (grant_pick) begin
      op_in = '{a: req1_a, b: req1_b, sel: alu_op_e'(req1_sel)};
    end else begin
      op_in = '{a: req0_a, b: req0_b, sel: alu_op_e'(req0_sel)};
    end
  end

  // Next-state and handshake outputs. Ready is combinational in IDLE and is
  // also masked by rst so nothing appears accepted while reset is held.
  // Response ready is only looked at in RESP, so a stray ready while no
  // result is pending has no effect.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    resp_done  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((req0_valid || req1_valid) && !rst) begin
          accept     = 1'b1;
          req0_ready = ~grant_pick;
          req1_ready = grant_pick;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          resp_done  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset drops straight back to IDLE, abandoning any
  // operation that was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operation latch, result register and grant history. last_q resets to 1
  // so that the first contention after reset goes to requester 0. The
  // grant history only advances once the response has actually been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      y_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        grant_q <= grant_pick;
      end
      if (state == ST_EXEC) begin
        y_q    <= alu_y;
        cout_q <= alu_cout;
      end
      if (resp_done) begin
        last_q <= grant_q;
      end
    end
  end

  alu_arbiter_alu u_alu (
    .a    (op_q.a),
    .b    (op_q.b),
    .sel  (op_q.sel),
    .y    (alu_y),
    .cout (alu_cout)
  );

  // Both response ports expose the single result register; only the owner
  // sees valid, and the register is frozen for the whole of RESP.
  assign rsp0_y    = y_q;
  assign rsp0_cout = cout_q;
  assign rsp1_y    = y_q;
  assign rsp1_cout = cout_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter. Two instances share every input: "rr" is
// the round-robin build, "fp" the fixed-priority build. Inputs change on the
// falling edge and outputs are sampled on the falling edge (or shortly after
// a change), away from the rising active edge.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic       rsp0_ready, rsp1_ready;

  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [3:0] rsp0_y, rsp1_y;
  logic       rsp0_cout, rsp1_cout, busy;

  logic       fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [3:0] fp_rsp0_y, fp_rsp1_y;
  logic       fp_rsp0_cout, fp_rsp1_cout, fp_busy;

  int n_checks;
  int n_fails;

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_y(rsp0_y), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_y(rsp1_y), .rsp1_cout(rsp1_cout),
    .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_y(fp_rsp0_y), .rsp0_cout(fp_rsp0_cout),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_y(fp_rsp1_y), .rsp1_cout(fp_rsp1_cout),
    .busy(fp_busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present an operation on requester n.
  task automatic applyStimulus(input bit n, input logic [3:0] a,
                               input logic [3:0] b, input logic [2:0] sel);
    if (!n) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  // Reset state, including ready masking while valids are high under reset.
  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); end
    n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
    n_checks++; if (rsp0_y !== 4'h0 || rsp0_cout !== 1'b0 || rsp1_y !== 4'h0 || rsp1_cout !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_result: got %h/%b %h/%b want 0/0 0/0", rsp0_y, rsp0_cout, rsp1_y, rsp1_cout); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || fp_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_hold_busy: got %b%b want 00", busy, fp_busy); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  // Both requesters valid continuously: rr alternates 0,1,0,1 starting at 0,
  // fp always grants 0. Operands are scrambled while in flight to show the
  // latched copy is what gets computed.
  task automatic test_contention();
    logic g;
    applyStimulus(1'b0, 4'h1, 4'h2, 3'b000);
    applyStimulus(1'b1, 4'h7, 4'h3, 3'b001);
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      n_checks++; if (req0_ready !== ~g || req1_ready !== g) begin n_fails++; $display("[TB] FAIL rr_grant%0d: got %b%b want %b%b", k, req1_ready, req0_ready, g, ~g); end
      n_checks++; if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL fp_grant%0d: got %b%b want 01", k, fp_req1_ready, fp_req0_ready); end
      @(negedge clk);
      req0_a = 4'hF; req0_b = 4'hF; req0_sel = 3'b111;
      req1_a = 4'hF; req1_b = 4'hF; req1_sel = 3'b111;
      n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL cont_busy%0d: got %b want 1", k, busy); end
      @(negedge clk);
      if (!g) begin
        n_checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_y !== 4'h3 || rsp0_cout !== 1'b0) begin n_fails++; $display("[TB] FAIL rr_rsp%0d: got v=%b%b y=%h c=%b want v=01 y=3 c=0", k, rsp1_valid, rsp0_valid, rsp0_y, rsp0_cout); end
      end else begin
        n_checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_y !== 4'h4 || rsp1_cout !== 1'b0) begin n_fails++; $display("[TB] FAIL rr_rsp%0d: got v=%b%b y=%h c=%b want v=10 y=4 c=0", k, rsp1_valid, rsp0_valid, rsp1_y, rsp1_cout); end
      end
      n_checks++; if (fp_rsp0_valid !== 1'b1 || fp_rsp1_valid !== 1'b0 || fp_rsp0_y !== 4'h3) begin n_fails++; $display("[TB] FAIL fp_rsp%0d: got v=%b%b y=%h want v=01 y=3", k, fp_rsp1_valid, fp_rsp0_valid, fp_rsp0_y); end
      req0_a = 4'h1; req0_b = 4'h2; req0_sel = 3'b000;
      req1_a = 4'h7; req1_b = 4'h3; req1_sel = 3'b001;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Single add with carry on requester 0, checking exact latency.
  task automatic test_req0_add();
    applyStimulus(1'b0, 4'h9, 4'h8, 3'b000);
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL add_ready: got %b%b want 01", req1_ready, req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin n_fails++; $display("[TB] FAIL add_exec: got v=%b busy=%b want v=0 busy=1", rsp0_valid, busy); end
    @(negedge clk);
    n_checks++; if (rsp0_valid !== 1'b1 || rsp0_y !== 4'h1 || rsp0_cout !== 1'b1) begin n_fails++; $display("[TB] FAIL add_rsp: got v=%b y=%h c=%b want v=1 y=1 c=1", rsp0_valid, rsp0_y, rsp0_cout); end
    n_checks++; if (rsp1_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL add_rsp1_quiet: got %b want 0", rsp1_valid); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL add_done: got busy=%b v=%b want 0 0", busy, rsp0_valid); end
  endtask

  // Opcode sweep on requester 1 with hand-computed results.
  task automatic test_req1_ops();
    logic [3:0] ta [10];
    logic [3:0] tb [10];
    logic [2:0] ts [10];
    logic [3:0] ty [10];
    logic       tc [10];
    ta = '{4'h3, 4'h3, 4'hC, 4'hC, 4'hC, 4'hC, 4'h5, 4'h2, 4'hF, 4'h5};
    tb = '{4'h5, 4'h1, 4'h6, 4'hA, 4'hA, 4'hA, 4'h0, 4'h3, 4'hE, 4'h5};
    ts = '{3'b001, 3'b110, 3'b111, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b110, 3'b001};
    ty = '{4'hE, 4'h6, 4'h3, 4'h8, 4'hE, 4'h6, 4'hA, 4'h5, 4'hC, 4'h0};
    tc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, ta[i], tb[i], ts[i]);
      #1;
      n_checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL op%0d_ready: got %b%b want 10", i, req1_ready, req0_ready); end
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_y !== ty[i] || rsp1_cout !== tc[i]) begin n_fails++; $display("[TB] FAIL op%0d_rsp: got v=%b%b y=%h c=%b want v=10 y=%h c=%b", i, rsp1_valid, rsp0_valid, rsp1_y, rsp1_cout, ty[i], tc[i]); end
      @(negedge clk);
    end
  endtask

  // Response held back for 10 cycles; a waiting requester 1 must not be
  // accepted until the held result is consumed.
  task automatic test_backpressure();
    rsp0_ready = 1'b0;
    applyStimulus(1'b0, 4'h6, 4'h7, 3'b001);
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    applyStimulus(1'b1, 4'h1, 4'h1, 3'b000);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rsp0_valid !== 1'b1 || rsp0_y !== 4'hF || rsp0_cout !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_hold%0d: got v=%b y=%h c=%b want v=1 y=f c=1", i, rsp0_valid, rsp0_y, rsp0_cout); end
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_stall%0d: got r=%b%b busy=%b want r=00 busy=1", i, req1_ready, req0_ready, busy); end
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_release: got busy=%b v=%b r1=%b want 0 0 1", busy, rsp0_valid, req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_y !== 4'h2 || rsp1_cout !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_next: got v=%b y=%h c=%b want v=1 y=2 c=0", rsp1_valid, rsp1_y, rsp1_cout); end
    @(negedge clk);
  endtask

  // Reset asserted between clock edges during EXEC: outputs clear at once,
  // the aborted op never responds, and a fresh request completes normally.
  task automatic test_reset_mid();
    applyStimulus(1'b0, 4'hF, 4'h1, 3'b000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || fp_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_busy: got %b%b want 00", busy, fp_busy); end
    n_checks++; if (rsp0_valid !== 1'b0 || rsp0_y !== 4'h0 || rsp0_cout !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_rsp: got v=%b y=%h c=%b want 0 0 0", rsp0_valid, rsp0_y, rsp0_cout); end
    n_checks++; if (req0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_ready: got %b want 0", req0_ready); end
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_quiet%0d: got v=%b%b busy=%b want 00 0", i, rsp1_valid, rsp0_valid, busy); end
    end
    applyStimulus(1'b0, 4'h4, 4'h4, 3'b000);
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_new_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp0_valid !== 1'b1 || rsp0_y !== 4'h8 || rsp0_cout !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_new_rsp: got v=%b y=%h c=%b want v=1 y=8 c=0", rsp0_valid, rsp0_y, rsp0_cout); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_new_done: got %b want 0", busy); end
  endtask

  // Test sequence.
  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    req0_valid = 1'b0; req0_a = 4'h0; req0_b = 4'h0; req0_sel = 3'b000;
    req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0; req1_sel = 3'b000;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    test_reset();
    test_contention();
    test_req0_add();
    test_req1_ops();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
